// File: rtl/reservation_station.sv
// Reservation station for ALU/branch ops: buffers issued ops, snoops the ALU and LSB
// result buses for pending operands, and dispatches one ready op per cycle.
module reservation_station #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned ROB_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [5:0]       issue_opcode,
    input  logic [31:0]      issue_val1,
    input  logic [31:0]      issue_val2,
    input  logic [ROB_W-1:0] issue_dep1,
    input  logic [ROB_W-1:0] issue_dep2,
    input  logic             issue_has_dep1,
    input  logic             issue_has_dep2,
    input  logic [ROB_W-1:0] issue_rob_index,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic             cdb_alu_valid,
    input  logic [ROB_W-1:0] cdb_alu_rob,
    input  logic [31:0]      cdb_alu_value,
    input  logic             cdb_lsb_valid,
    input  logic [ROB_W-1:0] cdb_lsb_rob,
    input  logic [31:0]      cdb_lsb_value,
    output logic             rs_full,
    output logic             alu_valid,
    output logic [5:0]       alu_opcode,
    output logic [31:0]      alu_val1,
    output logic [31:0]      alu_val2,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [ROB_W-1:0] alu_rob_index
);
    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef struct packed {
        logic             busy;
        logic [5:0]       opcode;
        logic             has_dep1;
        logic             has_dep2;
        logic [ROB_W-1:0] dep1;
        logic [ROB_W-1:0] dep2;
        logic [ROB_W-1:0] rob;
        logic [31:0]      val1;
        logic [31:0]      val2;
        logic [31:0]      imm;
        logic [31:0]      pc;
    } entry_t;

    typedef struct packed {
        logic             valid;
        logic [5:0]       opcode;
        logic [31:0]      val1;
        logic [31:0]      val2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [ROB_W-1:0] rob;
    } disp_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];
    disp_t  out_q;
    disp_t  out_d;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             disp_found;
    logic [IDX_W-1:0] disp_idx;
    logic [CNT_W-1:0] busy_cnt;

    // Returns {has_dep, value} after checking both result buses; ALU bus wins a tie.
    function automatic logic [32:0] resolve(input logic             has_dep,
                                            input logic [ROB_W-1:0] dep,
                                            input logic [31:0]      val);
        if (has_dep && cdb_alu_valid && dep == cdb_alu_rob) begin
            return {1'b0, cdb_alu_value};
        end
        if (has_dep && cdb_lsb_valid && dep == cdb_lsb_rob) begin
            return {1'b0, cdb_lsb_value};
        end
        return {has_dep, val};
    endfunction

    // Free/ready selection looks only at start-of-cycle state, so an entry freed by
    // dispatch is never refilled on the same edge and wakeups take a cycle to dispatch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        disp_found = 1'b0;
        disp_idx   = '0;
        busy_cnt   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (ent_q[IDX_W'(i)].busy) begin
                busy_cnt = busy_cnt + CNT_W'(1);
            end
            if (!ent_q[IDX_W'(i)].busy && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_q[IDX_W'(i)].busy && !ent_q[IDX_W'(i)].has_dep1 &&
                !ent_q[IDX_W'(i)].has_dep2 && !disp_found) begin
                disp_found = 1'b1;
                disp_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ent_d       = ent_q;
        out_d       = out_q;
        out_d.valid = 1'b0;
        if (flush) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_d[IDX_W'(i)].busy = 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (ent_q[IDX_W'(i)].busy) begin
                    {ent_d[IDX_W'(i)].has_dep1, ent_d[IDX_W'(i)].val1} =
                        resolve(ent_q[IDX_W'(i)].has_dep1, ent_q[IDX_W'(i)].dep1, ent_q[IDX_W'(i)].val1);
                    {ent_d[IDX_W'(i)].has_dep2, ent_d[IDX_W'(i)].val2} =
                        resolve(ent_q[IDX_W'(i)].has_dep2, ent_q[IDX_W'(i)].dep2, ent_q[IDX_W'(i)].val2);
                end
            end
            if (disp_found) begin
                out_d.valid           = 1'b1;
                out_d.opcode          = ent_q[disp_idx].opcode;
                out_d.val1            = ent_q[disp_idx].val1;
                out_d.val2            = ent_q[disp_idx].val2;
                out_d.imm             = ent_q[disp_idx].imm;
                out_d.pc              = ent_q[disp_idx].pc;
                out_d.rob             = ent_q[disp_idx].rob;
                ent_d[disp_idx].busy  = 1'b0;
            end
            if (issue_valid && free_found) begin
                ent_d[free_idx].busy   = 1'b1;
                ent_d[free_idx].opcode = issue_opcode;
                ent_d[free_idx].dep1   = issue_dep1;
                ent_d[free_idx].dep2   = issue_dep2;
                ent_d[free_idx].rob    = issue_rob_index;
                ent_d[free_idx].imm    = issue_imm;
                ent_d[free_idx].pc     = issue_pc;
                {ent_d[free_idx].has_dep1, ent_d[free_idx].val1} =
                    resolve(issue_has_dep1, issue_dep1, issue_val1);
                {ent_d[free_idx].has_dep2, ent_d[free_idx].val2} =
                    resolve(issue_has_dep2, issue_dep2, issue_val2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_q[IDX_W'(i)] <= '0;
            end
            out_q <= '0;
        end else if (rdy) begin
            ent_q <= ent_d;
            out_q <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && !flush && issue_valid) begin
            assert (free_found)
            else $error("reservation_station: issue with no free entry, op dropped");
        end
    end

    // Full at one free slot to absorb the issuer's one-cycle pipeline latency.
    assign rs_full       = (CNT_W'(RS_SIZE) - busy_cnt) <= CNT_W'(1);
    assign alu_valid     = out_q.valid;
    assign alu_opcode    = out_q.opcode;
    assign alu_val1      = out_q.val1;
    assign alu_val2      = out_q.val2;
    assign alu_imm       = out_q.imm;
    assign alu_pc        = out_q.pc;
    assign alu_rob_index = out_q.rob;

endmodule

// File: tb/tb_reservation_station.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// table-based model of the station's issue/wakeup/dispatch rules.
module tb_reservation_station;
    localparam int RS = 16;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        issue_valid;
    logic [5:0]  issue_opcode;
    logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
    logic [5:0]  issue_dep1, issue_dep2, issue_rob_index;
    logic        issue_has_dep1, issue_has_dep2;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [5:0]  cdb_alu_rob, cdb_lsb_rob;
    logic [31:0] cdb_alu_value, cdb_lsb_value;
    logic        rs_full, alu_valid;
    logic [5:0]  alu_opcode, alu_rob_index;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;

    reservation_station #(.RS_SIZE(16), .ROB_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_val1(issue_val1), .issue_val2(issue_val2),
        .issue_dep1(issue_dep1), .issue_dep2(issue_dep2),
        .issue_has_dep1(issue_has_dep1), .issue_has_dep2(issue_has_dep2),
        .issue_rob_index(issue_rob_index), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob(cdb_alu_rob), .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob(cdb_lsb_rob), .cdb_lsb_value(cdb_lsb_value),
        .rs_full(rs_full), .alu_valid(alu_valid), .alu_opcode(alu_opcode),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_rob_index(alu_rob_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        busy;
        bit        h1, h2;
        bit [5:0]  op, d1, d2, rob;
        bit [31:0] v1, v2, imm, pc;
    } ment_t;

    ment_t     m [RS];
    bit        e_valid;
    bit [5:0]  e_op, e_rob;
    bit [31:0] e_v1, e_v2, e_imm, e_pc;
    int        n_assert = 0;
    int        n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cdb_hit(input bit [5:0] tag, output bit [31:0] v);
        if (cdb_alu_valid && cdb_alu_rob == tag) begin
            v = cdb_alu_value;
            return 1'b1;
        end
        if (cdb_lsb_valid && cdb_lsb_rob == tag) begin
            v = cdb_lsb_value;
            return 1'b1;
        end
        v = '0;
        return 1'b0;
    endfunction

    function automatic int model_free();
        int n = 0;
        foreach (m[i]) if (!m[i].busy) n++;
        return n;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int        disp = -1;
        int        slot = -1;
        bit [31:0] tv;
        if (rst) begin
            foreach (m[i]) m[i].busy = 1'b0;
            e_valid = 1'b0;
            e_op = '0; e_rob = '0; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0;
            return;
        end
        if (!rdy) return;
        if (flush) begin
            foreach (m[i]) m[i].busy = 1'b0;
            e_valid = 1'b0;
            return;
        end
        for (int i = RS - 1; i >= 0; i--) begin
            if (m[i].busy && !m[i].h1 && !m[i].h2) disp = i;
            if (!m[i].busy) slot = i;
        end
        e_valid = (disp >= 0);
        if (disp >= 0) begin
            e_op = m[disp].op; e_rob = m[disp].rob; e_v1 = m[disp].v1;
            e_v2 = m[disp].v2; e_imm = m[disp].imm; e_pc = m[disp].pc;
            m[disp].busy = 1'b0;
        end
        foreach (m[i]) begin
            if (m[i].busy && m[i].h1 && cdb_hit(m[i].d1, tv)) begin m[i].h1 = 1'b0; m[i].v1 = tv; end
            if (m[i].busy && m[i].h2 && cdb_hit(m[i].d2, tv)) begin m[i].h2 = 1'b0; m[i].v2 = tv; end
        end
        if (issue_valid && slot >= 0) begin
            m[slot].busy = 1'b1;
            m[slot].op = issue_opcode; m[slot].rob = issue_rob_index;
            m[slot].imm = issue_imm; m[slot].pc = issue_pc;
            m[slot].d1 = issue_dep1; m[slot].d2 = issue_dep2;
            m[slot].h1 = issue_has_dep1; m[slot].v1 = issue_val1;
            m[slot].h2 = issue_has_dep2; m[slot].v2 = issue_val2;
            if (m[slot].h1 && cdb_hit(m[slot].d1, tv)) begin m[slot].h1 = 1'b0; m[slot].v1 = tv; end
            if (m[slot].h2 && cdb_hit(m[slot].d2, tv)) begin m[slot].h2 = 1'b0; m[slot].v2 = tv; end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("alu_valid", alu_valid, e_valid);
        chk("rs_full", rs_full, model_free() <= 1);
        if (e_valid) begin
            chk("alu_opcode", alu_opcode, e_op);
            chk("alu_val1", alu_val1, e_v1);
            chk("alu_val2", alu_val2, e_v2);
            chk("alu_imm", alu_imm, e_imm);
            chk("alu_pc", alu_pc, e_pc);
            chk("alu_rob", alu_rob_index, e_rob);
        end
    endtask

    task automatic set_issue(input bit [5:0] op, input bit [31:0] v1, input bit [31:0] v2,
                             input bit h1, input bit [5:0] d1, input bit h2, input bit [5:0] d2,
                             input bit [5:0] rob);
        issue_valid = 1'b1; issue_opcode = op;
        issue_val1 = v1; issue_val2 = v2;
        issue_has_dep1 = h1; issue_dep1 = d1;
        issue_has_dep2 = h2; issue_dep2 = d2;
        issue_rob_index = rob;
        issue_imm = $urandom; issue_pc = $urandom;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_opcode = '0; issue_val1 = '0; issue_val2 = '0;
        issue_dep1 = '0; issue_dep2 = '0; issue_has_dep1 = 1'b0; issue_has_dep2 = 1'b0;
        issue_rob_index = '0; issue_imm = '0; issue_pc = '0;
        cdb_alu_valid = 1'b0; cdb_alu_rob = '0; cdb_alu_value = '0;
        cdb_lsb_valid = 1'b0; cdb_lsb_rob = '0; cdb_lsb_value = '0;

        cycle(); cycle();
        chk("rst_valid", alu_valid, 0);
        chk("rst_full", rs_full, 0);
        chk("rst_data", {alu_opcode, alu_val1, alu_val2}, 0);
        chk("rst_data2", {alu_imm, alu_pc, alu_rob_index}, 0);
        rst = 1'b0;

        // 1: ready op dispatches two edges after issue
        set_issue(6'd1, 32'd5, 32'd7, 1'b0, 6'd0, 1'b0, 6'd0, 6'd3);
        cycle();
        chk("t1_early", alu_valid, 0);
        idle_inputs();
        cycle();
        chk("t1_valid", alu_valid, 1);
        chk("t1_val1", alu_val1, 5);
        chk("t1_val2", alu_val2, 7);
        chk("t1_rob", alu_rob_index, 3);

        // 2: dependency resolved by the ALU bus
        set_issue(6'd2, 32'd0, 32'd1, 1'b1, 6'd9, 1'b0, 6'd0, 6'd10);
        cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t2_wait", alu_valid, 0);
        end
        cdb_alu_valid = 1'b1; cdb_alu_rob = 6'd9; cdb_alu_value = 32'h20;
        cycle();
        chk("t2_wake_cycle", alu_valid, 0);
        idle_inputs();
        cycle();
        chk("t2_valid", alu_valid, 1);
        chk("t2_val1", alu_val1, 32'h20);
        chk("t2_rob", alu_rob_index, 10);

        // 3: same-cycle LSB bypass at issue
        set_issue(6'd3, 32'd0, 32'd2, 1'b1, 6'd4, 1'b0, 6'd0, 6'd11);
        cdb_lsb_valid = 1'b1; cdb_lsb_rob = 6'd4; cdb_lsb_value = 32'hAB;
        cycle();
        idle_inputs();
        cycle();
        chk("t3_valid", alu_valid, 1);
        chk("t3_val1", alu_val1, 32'hAB);
        cycle();

        // rdy low: a broadcast during a stalled cycle is ignored
        set_issue(6'd4, 32'd0, 32'd0, 1'b0, 6'd0, 1'b1, 6'd12, 6'd12);
        cycle();
        idle_inputs();
        rdy = 1'b0;
        cdb_alu_valid = 1'b1; cdb_alu_rob = 6'd12; cdb_alu_value = 32'h77;
        cycle();
        rdy = 1'b1;
        idle_inputs();
        cycle(); cycle();
        chk("rdy_ignored", alu_valid, 0);
        cdb_alu_valid = 1'b1; cdb_alu_rob = 6'd12; cdb_alu_value = 32'h99;
        cycle();
        idle_inputs();
        cycle();
        chk("rdy_drain", alu_val2, 32'h99);
        cycle();

        // 4: fill all 16 entries; full asserts at one free slot
        for (int k = 0; k < 15; k++) begin
            set_issue(6'd5, 32'd0, 32'd0, 1'b1, 6'd50, 1'b0, 6'd0, 6'(k));
            cycle();
            if (k == 13) chk("t4_free2", rs_full, 0);
        end
        chk("t4_full15", rs_full, 1);
        set_issue(6'd5, 32'd0, 32'd0, 1'b1, 6'd50, 1'b0, 6'd0, 6'd15);
        cycle();
        chk("t4_full16", rs_full, 1);
        idle_inputs();
        cdb_alu_valid = 1'b1; cdb_alu_rob = 6'd50; cdb_alu_value = 32'h55;
        cycle();
        idle_inputs();
        for (int k = 0; k < 16; k++) begin
            cycle();
            chk("t4_disp_valid", alu_valid, 1);
            chk("t4_disp_rob", alu_rob_index, k);
        end
        cycle();
        chk("t4_empty", rs_full, 0);

        // 5: entries 0,2,5 woken together dispatch in index order
        for (int k = 0; k < 6; k++) begin
            set_issue(6'd6, 32'd0, 32'd0, 1'b1, (k == 0 || k == 2 || k == 5) ? 6'd30 : 6'd31,
                      1'b0, 6'd0, 6'(20 + k));
            cycle();
        end
        idle_inputs();
        cdb_alu_valid = 1'b1; cdb_alu_rob = 6'd30; cdb_alu_value = 32'h30;
        cycle();
        idle_inputs();
        cycle(); chk("t5_first", alu_rob_index, 20);
        cycle(); chk("t5_second", alu_rob_index, 22);
        cycle(); chk("t5_third", alu_rob_index, 25);
        cycle(); chk("t5_done", alu_valid, 0);
        cdb_lsb_valid = 1'b1; cdb_lsb_rob = 6'd31; cdb_lsb_value = 32'h31;
        cycle();
        idle_inputs();
        repeat (4) cycle();

        // 6: flush with a simultaneous issue empties the station
        for (int k = 0; k < 8; k++) begin
            set_issue(6'd7, 32'd0, 32'd0, 1'b1, 6'd40, 1'b1, 6'd40, 6'(k));
            cycle();
        end
        set_issue(6'd8, 32'd1, 32'd2, 1'b0, 6'd0, 1'b0, 6'd0, 6'd60);
        flush = 1'b1;
        cycle();
        idle_inputs();
        chk("t6_valid", alu_valid, 0);
        chk("t6_full", rs_full, 0);
        cdb_alu_valid = 1'b1; cdb_alu_rob = 6'd40; cdb_alu_value = 32'h40;
        cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_idle", alu_valid, 0);
        end

        // Random traffic against the model
        for (int it = 0; it < 3000; it++) begin
            rst   = (it == 1500);
            rdy   = rst || ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 49) == 0);
            issue_valid     = (model_free() > 0) && ($urandom_range(0, 2) != 0);
            issue_opcode    = 6'($urandom);
            issue_val1      = $urandom; issue_val2 = $urandom;
            issue_imm       = $urandom; issue_pc   = $urandom;
            issue_has_dep1  = $urandom_range(0, 1) != 0;
            issue_has_dep2  = $urandom_range(0, 1) != 0;
            issue_dep1      = 6'($urandom_range(0, 7));
            issue_dep2      = 6'($urandom_range(0, 7));
            issue_rob_index = 6'($urandom);
            cdb_alu_valid   = $urandom_range(0, 9) < 4;
            cdb_alu_rob     = 6'($urandom_range(0, 7));
            cdb_alu_value   = $urandom;
            cdb_lsb_valid   = $urandom_range(0, 9) < 4;
            cdb_lsb_rob     = 6'((cdb_alu_rob + 6'($urandom_range(1, 7))) % 8);
            cdb_lsb_value   = $urandom;
            cycle();
        end
        rst = 1'b0; rdy = 1'b1;
        idle_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
